rv32i_dmem_responder: RTL and testbench

- Data-memory responder, the memory end of the core's load/store interface.
- The core's LSU issues requests over a valid/ready request channel. This block services them after a programmable number of wait states and returns the result on a valid/ready response channel.
- Performs RV32I byte, half and word lane handling and sign/zero extension.
- Flags misaligned, out-of-range and illegal-size accesses.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/rv32i_lsu_lane.sv | 55 +++++
 rtl/rv32i_dmem_responder.sv | 131 +++++++++++++
 tb/tb_rv32i_dmem_responder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Shared constants for the RV32I data-memory path: funct3 codes, FSM states,
// wait-counter width.
package rv32i_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/rv32i_lsu_lane.sv
// Combinational RV32I lane handling: byte enables, store lane replication,
// load extract/extend, misalign and illegal-funct3 detection.
module rv32i_lsu_lane
  import rv32i_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wlane,
  output logic [31:0] rdata,
  output logic        misalign,
  output logic        illegal
);

  logic [31:0] shifted;

  // Align the addressed lane down to bit 0 and decode the access size
  always_comb begin
    shifted  = rword >> {addr_lo, 3'b000};
    be       = 4'b0000;
    wlane    = 32'h0;
    rdata    = 32'h0;
    misalign = 1'b0;
    illegal  = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be      = 4'b0001 << addr_lo;
        wlane   = {4{wdata[7:0]}};
        rdata   = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                   : {24'h0, shifted[7:0]};
        // unsigned variants only exist for loads
        illegal = we && (funct3 == F3_BU);
      end
      F3_H, F3_HU: begin
        be       = addr_lo[1] ? 4'b1100 : 4'b0011;
        wlane    = {2{wdata[15:0]}};
        rdata    = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                    : {16'h0, shifted[15:0]};
        misalign = addr_lo[0];
        illegal  = we && (funct3 == F3_HU);
      end
      F3_W: begin
        be       = 4'b1111;
        wlane    = wdata;
        rdata    = rword;
        misalign = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder: single outstanding load/store, programmable wait
// states, registered response held until the LSU accepts it.
module rv32i_dmem_responder
  import rv32i_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               we_q;
  logic [2:0]         f3_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [31:0]        wdata_q;
  logic [31:0]        mem [DEPTH];

  logic               hs, enter_resp, oor, err;
  logic               cur_we;
  logic [2:0]         cur_f3;
  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        cur_wdata;
  logic [AW-1:0]      idx;
  logic [3:0]         be;
  logic [31:0]        wlane, lane_rdata;
  logic               misalign, illegal;

  assign hs = req_valid && req_ready;

  // With zero wait states RESP is entered on the acceptance edge itself, so
  // the live request is used while IDLE and the latched copy afterwards.
  assign cur_we    = (state == ST_IDLE) ? req_we     : we_q;
  assign cur_f3    = (state == ST_IDLE) ? req_funct3 : f3_q;
  assign cur_addr  = (state == ST_IDLE) ? req_addr   : addr_q;
  assign cur_wdata = (state == ST_IDLE) ? req_wdata  : wdata_q;

  assign idx = cur_addr[AW+1:2];
  assign oor = cur_addr[ADDR_W-1:2] >= (ADDR_W-2)'(DEPTH);
  assign err = misalign | illegal | oor;

  assign enter_resp = (state == ST_IDLE && hs && LATENCY == 0) ||
                      (state == ST_WAIT && cnt == CNT_W'(1));

  rv32i_lsu_lane u_lane (
    .we       (cur_we),
    .funct3   (cur_f3),
    .addr_lo  (cur_addr[1:0]),
    .wdata    (cur_wdata),
    .rword    (mem[idx]),
    .be       (be),
    .wlane    (wlane),
    .rdata    (lane_rdata),
    .misalign (misalign),
    .illegal  (illegal)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  // FSM next-state
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (hs) state_nx = (LATENCY == 0) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (cnt == CNT_W'(1)) state_nx = ST_RESP;
      ST_RESP: if (rsp_valid && rsp_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // FSM outputs: acceptance depends only on state, never on req_valid
  always_comb begin
    req_ready = (state == ST_IDLE) && rst;
  end

  // Request latch, wait counter and registered response
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else begin
      if (hs) begin
        we_q    <= req_we;
        f3_q    <= req_funct3;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        cnt     <= CNT_W'(LATENCY);
      end else if (state == ST_WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (enter_resp) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= (err || cur_we) ? 32'h0 : lane_rdata;
        rsp_err   <= err;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // Store commit on RESP entry; contents survive reset, faulting stores are dropped
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed bench: DUT 0 with LATENCY=2, DUT 1 with LATENCY=0, shared clock,
// reset and request payload; per-DUT handshake signals.
module tb_rv32i_dmem_responder;

  localparam int DEPTH = 1024;
  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [1:0]        req_valid = '0;
  logic [1:0]        req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = 3'b0;
  logic [31:0]       req_addr = 32'h0;
  logic [31:0]       req_wdata = 32'h0;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready = '0;
  logic [1:0][31:0]  rsp_rdata;
  logic [1:0]        rsp_err;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  rv32i_dmem_responder #(.DEPTH(DEPTH), .LATENCY(2), .ADDR_W(32)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
  );

  rv32i_dmem_responder #(.DEPTH(DEPTH), .LATENCY(0), .ADDR_W(32)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
  );

  // One full transaction on DUT d. lat = samples after the acceptance edge
  // until rsp_valid is seen (1 = right after it); -1 on timeout.
  task automatic xact(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic e, output int lat);
    int n;
    rd = 'x; e = 1'bx; lat = -1;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid[d] = 1'b1;
    n = 0;
    while (!req_ready[d] && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready[d]) begin req_valid[d] = 1'b0; return; end
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    n = 1;
    while (!rsp_valid[d] && n < 50) begin @(posedge clk); #1; n++; end
    if (!rsp_valid[d]) return;
    lat = n; rd = rsp_rdata[d]; e = rsp_err[d];
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (rsp_valid !== 2'b00) begin fails++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++;
    if (req_ready !== 2'b00) begin fails++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    checks++;
    if (rsp_rdata[0] !== 32'h0 || rsp_err[0] !== 1'b0) begin
      fails++; $display("FAIL reset_rsp_regs rdata=%h err=%b exp 0/0", rsp_rdata[0], rsp_err[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 2'b11) begin fails++; $display("FAIL release_req_ready got=%b exp=11", req_ready); end
    checks++;
    if (rsp_valid !== 2'b00) begin fails++; $display("FAIL release_rsp_valid got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic e; int lat;
    xact(0, 1'b1, W, 32'h10, 32'hDEADBEEF, rd, e, lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL sw_latency got=%0d exp=3", lat); end
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sw_rsp rdata=%h err=%b exp 0/0", rd, e); end
    xact(0, 1'b0, W, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 3) begin fails++; $display("FAIL lw_latency got=%0d exp=3", lat); end
    checks++;
    if (rd !== 32'hDEADBEEF || e !== 1'b0) begin fails++; $display("FAIL lw_data rdata=%h err=%b exp DEADBEEF/0", rd, e); end
  endtask

  task automatic test_subword();
    logic [31:0] rd; logic e; int lat;
    xact(0, 1'b1, B, 32'h13, 32'h00000080, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b0) begin fails++; $display("FAIL sb_rsp rdata=%h err=%b exp 0/0", rd, e); end
    xact(0, 1'b0, B, 32'h13, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin fails++; $display("FAIL lb_13 rdata=%h err=%b exp FFFFFF80/0", rd, e); end
    xact(0, 1'b0, BU, 32'h13, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h00000080 || e !== 1'b0) begin fails++; $display("FAIL lbu_13 rdata=%h err=%b exp 00000080/0", rd, e); end
    xact(0, 1'b0, W, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL lw_after_sb rdata=%h exp 80ADBEEF", rd); end
    xact(0, 1'b0, H, 32'h12, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFF80AD || e !== 1'b0) begin fails++; $display("FAIL lh_12 rdata=%h err=%b exp FFFF80AD/0", rd, e); end
    xact(0, 1'b0, HU, 32'h12, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h000080AD || e !== 1'b0) begin fails++; $display("FAIL lhu_12 rdata=%h err=%b exp 000080AD/0", rd, e); end
    xact(0, 1'b0, B, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hFFFFFFEF) begin fails++; $display("FAIL lb_10 rdata=%h exp FFFFFFEF", rd); end
    xact(0, 1'b0, BU, 32'h11, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h000000BE) begin fails++; $display("FAIL lbu_11 rdata=%h exp 000000BE", rd); end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic e; int lat;
    xact(0, 1'b0, H, 32'h11, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lh_misalign rdata=%h err=%b exp 0/1", rd, e); end
    xact(0, 1'b1, W, 32'h12, 32'h11223344, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL sw_misalign rdata=%h err=%b exp 0/1", rd, e); end
    xact(0, 1'b0, W, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80ADBEEF || e !== 1'b0) begin fails++; $display("FAIL lw_after_bad_sw rdata=%h err=%b exp 80ADBEEF/0", rd, e); end
    xact(0, 1'b0, 3'b011, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL f3_011 rdata=%h err=%b exp 0/1", rd, e); end
    xact(0, 1'b1, BU, 32'h10, 32'h55, rd, e, lat);
    checks++;
    if (e !== 1'b1) begin fails++; $display("FAIL store_bu err=%b exp 1", e); end
    xact(0, 1'b0, W, 32'h10, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80ADBEEF) begin fails++; $display("FAIL lw_after_store_bu rdata=%h exp 80ADBEEF", rd); end
  endtask

  task automatic test_range_stall();
    int n;
    req_we = 1'b0; req_funct3 = W; req_addr = 32'(4*DEPTH); req_wdata = 32'h0;
    req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!rsp_valid[0] && n < 50) begin @(posedge clk); #1; n++; end
    checks++;
    if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 32'h0) begin
      fails++; $display("FAIL oor_rsp valid=%b err=%b rdata=%h exp 1/1/0", rsp_valid[0], rsp_err[0], rsp_rdata[0]);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (rsp_valid[0] !== 1'b1 || rsp_err[0] !== 1'b1 || rsp_rdata[0] !== 32'h0 || req_ready[0] !== 1'b0) begin
        fails++; $display("FAIL stall_hold cyc=%0d valid=%b err=%b rdata=%h req_ready=%b exp 1/1/0/0",
                          i, rsp_valid[0], rsp_err[0], rsp_rdata[0], req_ready[0]);
      end
    end
    rsp_ready[0] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[0] = 1'b0;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1) begin
      fails++; $display("FAIL stall_release valid=%b req_ready=%b exp 0/1", rsp_valid[0], req_ready[0]);
    end
    checks++;
    if (rsp_err[0] !== 1'b1) begin fails++; $display("FAIL err_retained got=%b exp 1", rsp_err[0]); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] rd; logic e; int lat; int n; logic seen;
    xact(0, 1'b1, W, 32'h20, 32'hCAFEF00D, rd, e, lat);
    req_we = 1'b1; req_funct3 = W; req_addr = 32'h20; req_wdata = 32'h12345678;
    req_valid[0] = 1'b1;
    n = 0;
    while (!req_ready[0] && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b0) begin
      fails++; $display("FAIL abort_in_reset valid=%b req_ready=%b exp 0/0", rsp_valid[0], req_ready[0]);
    end
    rst = 1'b1;
    seen = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid[0]) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_response got rsp_valid=1 exp 0"); end
    xact(0, 1'b0, W, 32'h20, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'hCAFEF00D || e !== 1'b0) begin fails++; $display("FAIL abort_store_dropped rdata=%h err=%b exp CAFEF00D/0", rd, e); end
  endtask

  task automatic test_zero_latency();
    logic [31:0] rd; logic e; int lat;
    xact(1, 1'b1, W, 32'h40, 32'hA5A51234, rd, e, lat);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL lat0_sw_latency got=%0d exp=1", lat); end
    xact(1, 1'b0, HU, 32'h42, 32'h0, rd, e, lat);
    checks++;
    if (lat !== 1) begin fails++; $display("FAIL lat0_lhu_latency got=%0d exp=1", lat); end
    checks++;
    if (rd !== 32'h0000A5A5 || e !== 1'b0) begin fails++; $display("FAIL lat0_lhu rdata=%h err=%b exp 0000A5A5/0", rd, e); end
    xact(1, 1'b1, H, 32'h42, 32'h00008001, rd, e, lat);
    xact(1, 1'b0, W, 32'h40, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h80011234) begin fails++; $display("FAIL lat0_sh_merge rdata=%h exp 80011234", rd); end
    xact(1, 1'b0, W, 32'h41, 32'h0, rd, e, lat);
    checks++;
    if (rd !== 32'h0 || e !== 1'b1) begin fails++; $display("FAIL lat0_lw_misalign rdata=%h err=%b exp 0/1", rd, e); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_range_stall();
    test_reset_abort();
    test_zero_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
